load_issue_scheduler: RTL and testbench

- Round-robin arbiter and sequencer sharing one load memory port among NUM_REQ load requesters.
- Issues granted loads to memory and pushes each load's attributes (requester id + attribute payload) into the load-attributes FIFO.
- Pops the FIFO on each memory response and routes the response to the owning requester.
- Implements a flush/drain state machine that discards responses to loads issued before a flush.

---
 rtl/load_issue_scheduler.sv | 140 ++++++++++++++
 tb/tb_load_issue_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_issue_scheduler.sv
// Round-robin load issue onto one memory port; attributes tracked in an external in-order FIFO, responses routed back with 0-cycle latency.
// Issue stalls on ~mem_req_ready, flush, DRAIN, or a full FIFO without a same-cycle pop. Define LOAD_SCHED_STATS_EN for stat counters.
module load_issue_scheduler #(
    parameter int  NUM_REQ = 2,
    parameter int  ATTR_W  = 8,
    localparam int ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*ATTR_W-1:0] req_attr,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic [ID_W-1:0]          mem_req_id,
    input  logic                     mem_rsp_valid,
    output logic                     fifo_push,
    output logic                     fifo_potential_push,
    output logic [ID_W+ATTR_W-1:0]   fifo_data_in,
    output logic                     fifo_pop,
    input  logic                     fifo_valid,
    input  logic                     fifo_full,
    input  logic [ID_W+ATTR_W-1:0]   fifo_data_out,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [ATTR_W-1:0]        rsp_attr,
    input  logic                     flush,
    output logic                     drained
`ifdef LOAD_SCHED_STATS_EN
    ,
    output logic [31:0]              stat_issued,
    output logic [31:0]              stat_full_stall,
    output logic [31:0]              stat_discarded
`endif
);

    typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_rr_ptr;

    logic              w_run;
    logic              w_found;
    logic              w_issue_ok;
    logic              w_grant;
    logic [ID_W:0]     w_scan;
    logic [ID_W-1:0]   w_idx;
    logic [ID_W-1:0]   w_winner;
    logic [ID_W-1:0]   w_next_ptr;
    logic [ID_W-1:0]   w_rsp_id;
    logic [ATTR_W-1:0] w_attr_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_attr
        assign w_attr_arr[gi] = req_attr[gi*ATTR_W +: ATTR_W];
    end

    // Scan from the round-robin pointer upward, wrapping, first requester wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_scan   = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_scan >= (ID_W+1)'(NUM_REQ)) begin
                w_scan = w_scan - (ID_W+1)'(NUM_REQ);
            end
            w_idx = w_scan[ID_W-1:0];
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_run      = (r_state == ST_RUN);
    assign fifo_pop   = mem_rsp_valid & fifo_valid;
    // A same-cycle pop frees the slot a push needs when the FIFO is full.
    assign w_issue_ok = w_run & ~flush & mem_req_ready & (~fifo_full | fifo_pop);
    assign w_grant    = w_issue_ok & w_found;

    assign gnt                 = w_grant ? (NUM_REQ'(1) << w_winner) : '0;
    assign mem_req_valid       = w_grant;
    assign fifo_push           = w_grant;
    assign mem_req_id          = w_winner;
    assign fifo_data_in        = {w_winner, w_attr_arr[w_winner]};
    assign fifo_potential_push = (|req) & w_run;

    assign w_rsp_id  = fifo_data_out[ID_W+ATTR_W-1:ATTR_W];
    assign rsp_attr  = fifo_data_out[ATTR_W-1:0];
    assign rsp_valid = (w_run & fifo_pop) ? (NUM_REQ'(1) << w_rsp_id) : '0;
    assign drained   = w_run & ~fifo_valid;

    assign w_next_ptr = (w_winner == ID_W'(NUM_REQ-1)) ? '0 : w_winner + ID_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_rr_ptr <= '0;
        end else begin
            if (w_grant) begin
                r_rr_ptr <= w_next_ptr;
            end
            case (r_state)
                ST_RUN:   if (flush && fifo_valid) r_state <= ST_DRAIN;
                ST_DRAIN: if (!fifo_valid)         r_state <= ST_RUN;
                default:                           r_state <= ST_RUN;
            endcase
        end
    end

`ifdef LOAD_SCHED_STATS_EN
    logic [31:0] r_stat_issued;
    logic [31:0] r_stat_full_stall;
    logic [31:0] r_stat_discarded;
    logic        w_full_stall;

    assign w_full_stall = (|req) & w_run & ~flush & mem_req_ready & fifo_full & ~fifo_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_issued     <= '0;
            r_stat_full_stall <= '0;
            r_stat_discarded  <= '0;
        end else begin
            if (w_grant && r_stat_issued != '1)          r_stat_issued     <= r_stat_issued + 32'd1;
            if (w_full_stall && r_stat_full_stall != '1) r_stat_full_stall <= r_stat_full_stall + 32'd1;
            if (!w_run && fifo_pop && r_stat_discarded != '1) r_stat_discarded <= r_stat_discarded + 32'd1;
        end
    end

    assign stat_issued     = r_stat_issued;
    assign stat_full_stall = r_stat_full_stall;
    assign stat_discarded  = r_stat_discarded;
`endif

    a_rsp_has_load: assert property (@(posedge clk) disable iff (rst) mem_rsp_valid |-> fifo_valid);
    a_gnt_onehot:   assert property (@(posedge clk) $onehot0(gnt));
    a_rsp_onehot:   assert property (@(posedge clk) $onehot0(rsp_valid));

endmodule

// File: tb/tb_load_issue_scheduler.sv
// Bench for load_issue_scheduler: plays the attributes FIFO and memory, checks against a queue-based reference.
module tb_load_issue_scheduler;
    localparam int N     = 2;
    localparam int AW    = 8;
    localparam int IW    = 1;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_attr;
    logic [N-1:0]    gnt;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [IW-1:0]   mem_req_id;
    logic            mem_rsp_valid;
    logic            fifo_push;
    logic            fifo_potential_push;
    logic [IW+AW-1:0] fifo_data_in;
    logic            fifo_pop;
    logic            fifo_valid;
    logic            fifo_full;
    logic [IW+AW-1:0] fifo_data_out;
    logic [N-1:0]    rsp_valid;
    logic [AW-1:0]   rsp_attr;
    logic            flush;
    logic            drained;
`ifdef LOAD_SCHED_STATS_EN
    logic [31:0]     stat_issued, stat_full_stall, stat_discarded;
    int              m_issued, m_stall, m_disc;
`endif

    load_issue_scheduler #(.NUM_REQ(N), .ATTR_W(AW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_attr(req_attr), .gnt(gnt),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_id(mem_req_id),
        .mem_rsp_valid(mem_rsp_valid), .fifo_push(fifo_push), .fifo_potential_push(fifo_potential_push),
        .fifo_data_in(fifo_data_in), .fifo_pop(fifo_pop), .fifo_valid(fifo_valid), .fifo_full(fifo_full),
        .fifo_data_out(fifo_data_out), .rsp_valid(rsp_valid), .rsp_attr(rsp_attr), .flush(flush),
        .drained(drained)
`ifdef LOAD_SCHED_STATS_EN
        , .stat_issued(stat_issued), .stat_full_stall(stat_full_stall), .stat_discarded(stat_discarded)
`endif
    );

    always #5 clk = ~clk;

    // Reference: outstanding loads in order, a pointer and a draining flag.
    logic [IW+AW-1:0] q[$];
    int               m_ptr;
    bit               m_drain;
    bit               e_push, e_pop, e_stall;
    int               e_winner;
    logic [IW+AW-1:0] e_din;
    int               n_cmp = 0;
    int               n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        fifo_valid    = (q.size() != 0);
        fifo_full     = (q.size() == DEPTH);
        fifo_data_out = (q.size() != 0) ? q[0] : '0;
    endtask

    task automatic set_idle();
        req = '0; req_attr = '0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic eval_cycle();
        bit               run, full, pop, ok, found;
        int               w, idx;
        logic [IW+AW-1:0] head;
        logic [AW-1:0]    a;
        logic [N-1:0]     e_gnt, e_rsp;
        #1;
        run   = !m_drain;
        full  = (q.size() == DEPTH);
        pop   = mem_rsp_valid && (q.size() != 0);
        ok    = run && !flush && mem_req_ready && (!full || pop);
        found = 0;
        w     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (!found && ((req >> idx) & 1) != 0) begin
                found = 1;
                w     = idx;
            end
        end
        a        = AW'(req_attr >> (w * AW));
        e_push   = ok && found;
        e_pop    = pop;
        e_winner = w;
        e_din    = {IW'(w), a};
        e_stall  = (req != 0) && run && !flush && mem_req_ready && full && !pop;
        e_gnt    = e_push ? N'(1 << w) : '0;
        head     = (q.size() != 0) ? q[0] : '0;
        e_rsp    = (run && pop) ? N'(1 << int'(head[IW+AW-1:AW])) : '0;
        chk("gnt", gnt, e_gnt);
        chk("mem_req_valid", mem_req_valid, e_push);
        chk("fifo_push", fifo_push, e_push);
        chk("fifo_potential_push", fifo_potential_push, (req != 0) && run);
        chk("fifo_pop", fifo_pop, pop);
        chk("rsp_valid", rsp_valid, e_rsp);
        chk("drained", drained, run && (q.size() == 0));
        if (e_push) begin
            chk("mem_req_id", mem_req_id, w);
            chk("fifo_data_in", fifo_data_in, e_din);
        end
        if (run && pop) chk("rsp_attr", rsp_attr, head[AW-1:0]);
    endtask

    task automatic tick();
        bit was_valid;
        if (rst) begin
            q.delete();
            m_ptr   = 0;
            m_drain = 0;
`ifdef LOAD_SCHED_STATS_EN
            m_issued = 0; m_stall = 0; m_disc = 0;
`endif
        end else begin
            was_valid = (q.size() != 0);
`ifdef LOAD_SCHED_STATS_EN
            m_issued += int'(e_push);
            m_stall  += int'(e_stall);
            m_disc   += int'(m_drain && e_pop);
`endif
            if (e_pop) void'(q.pop_front());
            if (e_push) begin
                q.push_back(e_din);
                m_ptr = (e_winner + 1) % N;
            end
            if (!m_drain && flush && was_valid) m_drain = 1;
            else if (m_drain && !was_valid)     m_drain = 0;
        end
        @(posedge clk);
        #1;
        drive_fifo();
    endtask

    initial begin
        logic [N-1:0] rr_seq [4];
        rr_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
        rst = 1'b1;
        set_idle();
        mem_req_ready = 1'b0;
        e_push = 0; e_pop = 0; e_stall = 0; e_winner = 0; e_din = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state with idle inputs.
        eval_cycle();
        chk("reset_drained", drained, 1'b1);
        tick();

        // Alternating grants with both requesting.
        for (int i = 0; i < 4; i++) begin
            set_idle();
            req = 2'b11;
            req_attr = N*AW'($urandom());
            eval_cycle();
            chk("rr_seq", gnt, rr_seq[i]);
            chk("rr_id", fifo_data_in[IW+AW-1:AW], i % 2);
            tick();
        end

        // FIFO full: stall, then same-cycle pop allows issue.
        set_idle();
        req = 2'b01;
        eval_cycle();
        chk("full_gnt", gnt, 2'b00);
        chk("full_push", fifo_push, 1'b0);
        tick();
        mem_rsp_valid = 1'b1;
        eval_cycle();
        chk("full_pop", fifo_pop, 1'b1);
        chk("full_pop_gnt", gnt, 2'b01);
        tick();
        while (q.size() != 0) begin
            set_idle();
            mem_rsp_valid = 1'b1;
            eval_cycle();
            tick();
        end

        // Responses return to their owners in order.
        set_idle(); req = 2'b10; req_attr = {8'hA5, 8'h00}; eval_cycle(); tick();
        set_idle(); req = 2'b01; req_attr = {8'h00, 8'h3C}; eval_cycle(); tick();
        set_idle(); mem_rsp_valid = 1'b1; eval_cycle();
        chk("rsp1_valid", rsp_valid, 2'b10);
        chk("rsp1_attr", rsp_attr, 8'hA5);
        tick();
        set_idle(); mem_rsp_valid = 1'b1; eval_cycle();
        chk("rsp2_valid", rsp_valid, 2'b01);
        chk("rsp2_attr", rsp_attr, 8'h3C);
        tick();

        // Flush with three outstanding loads.
        for (int i = 0; i < 3; i++) begin
            set_idle(); req = 2'b01; eval_cycle(); tick();
        end
        set_idle(); req = 2'b11; flush = 1'b1; eval_cycle();
        chk("flush_gnt", gnt, 2'b00);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_idle(); req = 2'b11; mem_rsp_valid = 1'b1; eval_cycle();
            chk("drain_rsp", rsp_valid, 2'b00);
            chk("drain_gnt", gnt, 2'b00);
            chk("drain_drained", drained, 1'b0);
            tick();
        end
        for (int i = 0; i < 4 && m_drain; i++) begin
            set_idle(); req = 2'b11; eval_cycle(); tick();
        end
        set_idle(); req = 2'b11; eval_cycle();
        chk("post_drain_drained", drained, 1'b1);
        chk("post_drain_gnt", gnt, 2'b10);
        tick();
        while (q.size() != 0) begin
            set_idle(); mem_rsp_valid = 1'b1; eval_cycle(); tick();
        end

        // Flush with nothing outstanding.
        set_idle(); req = 2'b01; flush = 1'b1; eval_cycle();
        chk("flush_empty_gnt", gnt, 2'b00);
        chk("flush_empty_drained", drained, 1'b1);
        tick();
        set_idle(); req = 2'b01; eval_cycle();
        chk("flush_empty_resume", gnt, 2'b01);
        tick();

        // Reset mid-stream with the pointer at 1.
        set_idle(); req = 2'b01; eval_cycle(); tick();
        set_idle(); rst = 1'b1; tick(); rst = 1'b0;
        set_idle(); req = 2'b11; eval_cycle();
        chk("post_reset_gnt", gnt, 2'b01);
        tick();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            req           = N'($urandom());
            req_attr      = N*AW'($urandom());
            mem_req_ready = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 19) == 0);
            mem_rsp_valid = (q.size() != 0) && ($urandom_range(0, 2) == 0);
            eval_cycle();
            tick();
        end

`ifdef LOAD_SCHED_STATS_EN
        chk("stat_issued", stat_issued, m_issued);
        chk("stat_full_stall", stat_full_stall, m_stall);
        chk("stat_discarded", stat_discarded, m_disc);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
